// File: rtl/alu_operand_join.sv
// Operand-join stage ahead of an ALU cell: two buffered operand streams are
// merged into one aligned pair according to the ALU operation code.

module alu_operand_join_fifo #(
    parameter int W     = 32,
    parameter int DEPTH = 2
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       push_i,
    input  logic                       pop_i,
    input  logic [W-1:0]               data_i,
    output logic [W-1:0]               head_o,
    output logic [$clog2(DEPTH):0]     cnt_o
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wr_q, wr_d;
    logic [AW-1:0] rd_q, rd_d;
    logic [AW:0]   cnt_q, cnt_d;

    always_comb begin
        wr_d  = wr_q;
        rd_d  = rd_q;
        cnt_d = cnt_q;
        if (push_i) begin
            wr_d = wr_q + 1'b1;
        end
        if (pop_i) begin
            rd_d = rd_q + 1'b1;
        end
        if (push_i && !pop_i) begin
            cnt_d = cnt_q + 1'b1;
        end else if (!push_i && pop_i) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            wr_q  <= wr_d;
            rd_q  <= rd_d;
            cnt_q <= cnt_d;
        end
    end

    // Storage is deliberately not reset; heads are don't-care while empty.
    always_ff @(posedge clk) begin
        if (reset_n && push_i) begin
            mem_q[wr_q] <= data_i;
        end
    end

    assign head_o = mem_q[rd_q];
    assign cnt_o  = cnt_q;
endmodule

// Handshakes: a token moves on a rising edge where valid & ready are both
// high; ready never depends on the same-cycle valid of the other side.
module alu_operand_join #(
    parameter int size  = 32,
    parameter int DEPTH = 2
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic [1:0]                 config_sig,
    input  logic [size-1:0]            in0,
    input  logic                       in0_valid,
    output logic                       in0_ready,
    input  logic [size-1:0]            in1,
    input  logic                       in1_valid,
    output logic                       in1_ready,
    output logic [size-1:0]            out0,
    output logic [size-1:0]            out1,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [$clog2(DEPTH):0]     cnt0,
    output logic [$clog2(DEPTH):0]     cnt1
);
    localparam int CW = $clog2(DEPTH) + 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    logic            req0, req1;
    logic            push0, push1, pop0, pop1, fire;
    logic [size-1:0] head0, head1;

    assign req0 = (config_sig != 2'd3);
    assign req1 = (config_sig != 2'd2);

    // Unused inputs are always ready so their tokens drain and are discarded.
    assign in0_ready = req0 ? (cnt0 < FULL) : 1'b1;
    assign in1_ready = req1 ? (cnt1 < FULL) : 1'b1;

    assign out_valid = (!req0 || (cnt0 != '0)) && (!req1 || (cnt1 != '0));
    assign fire      = out_valid && out_ready;

    assign push0 = req0 && in0_valid && in0_ready;
    assign push1 = req1 && in1_valid && in1_ready;
    assign pop0  = req0 && fire;
    assign pop1  = req1 && fire;

    alu_operand_join_fifo #(.W(size), .DEPTH(DEPTH)) u_fifo0 (
        .clk     (clk),
        .reset_n (reset_n),
        .push_i  (push0),
        .pop_i   (pop0),
        .data_i  (in0),
        .head_o  (head0),
        .cnt_o   (cnt0)
    );

    alu_operand_join_fifo #(.W(size), .DEPTH(DEPTH)) u_fifo1 (
        .clk     (clk),
        .reset_n (reset_n),
        .push_i  (push1),
        .pop_i   (pop1),
        .data_i  (in1),
        .head_o  (head1),
        .cnt_o   (cnt1)
    );

    assign out0 = req0 ? head0 : '0;
    assign out1 = req1 ? head1 : '0;
endmodule

// File: tb/tb_alu_operand_join.sv
// Directed bench for alu_operand_join: expected pairs are queued by the
// stimulus and checked by an independent output monitor.

module tb_alu_operand_join;
    localparam int W = 32;
    localparam int D = 2;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic [1:0]    config_sig = 2'd0;
    logic [W-1:0]  in0 = '0, in1 = '0;
    logic          in0_valid = 1'b0, in1_valid = 1'b0;
    logic          in0_ready, in1_ready;
    logic [W-1:0]  out0, out1;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [1:0]    cnt0, cnt1;

    logic [2*W-1:0] exp_q[$];
    int n_vec = 0;
    int n_err = 0;

    alu_operand_join #(.size(W), .DEPTH(D)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .config_sig (config_sig),
        .in0        (in0),
        .in0_valid  (in0_valid),
        .in0_ready  (in0_ready),
        .in1        (in1),
        .in1_valid  (in1_valid),
        .in1_ready  (in1_ready),
        .out0       (out0),
        .out1       (out1),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .cnt0       (cnt0),
        .cnt1       (cnt1)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic push_exp(input logic [W-1:0] a, input logic [W-1:0] b);
        exp_q.push_back({a, b});
    endtask

    // Monitor: every presented-and-accepted pair is matched against the queue.
    always @(negedge clk) begin
        logic [2*W-1:0] e;
        if (reset_n && out_valid === 1'b1 && out_ready === 1'b1) begin
            n_vec++;
            if (exp_q.size() == 0) begin
                n_err++;
                $display("FAIL unexpected_pair: got (%0d,%0d) expected none", out0, out1);
            end else begin
                e = exp_q.pop_front();
                if ({out0, out1} !== e) begin
                    n_err++;
                    $display("FAIL pair: got (%0d,%0d) expected (%0d,%0d)",
                             out0, out1, e[2*W-1:W], e[W-1:0]);
                end
            end
        end
    end

    initial begin
        // Reset with valid tokens presented: they must be ignored.
        reset_n = 1'b0; in0_valid = 1'b1; in1_valid = 1'b1; in0 = 32'd77; in1 = 32'd66;
        step(); step();
        check("rst_cnt0", 64'(cnt0), 64'd0);
        check("rst_cnt1", 64'(cnt1), 64'd0);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        reset_n = 1'b1; in0_valid = 1'b0; in1_valid = 1'b0;
        step();
        check("rst_in0_ready", 64'(in0_ready), 64'd1);
        check("rst_in1_ready", 64'(in1_ready), 64'd1);
        check("rst_cnt0_after", 64'(cnt0), 64'd0);

        // Join in config 0: in0 first, in1 three cycles later.
        config_sig = 2'd0; out_ready = 1'b1;
        push_exp(32'd5, 32'd3);
        in0 = 32'd5; in0_valid = 1'b1;
        step();
        in0_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check("join_wait_valid", 64'(out_valid), 64'd0);
            if (i < 2) step();
        end
        in1 = 32'd3; in1_valid = 1'b1;
        step();
        in1_valid = 1'b0;
        check("join_valid", 64'(out_valid), 64'd1);
        step();
        check("join_after_fire", 64'(out_valid), 64'd0);
        check("join_cnt0", 64'(cnt0), 64'd0);

        // Backpressure until FIFO0 is full, then release with in1 tokens.
        out_ready = 1'b0;
        in0 = 32'd1; in0_valid = 1'b1; step();
        in0 = 32'd2; step();
        check("full_cnt0", 64'(cnt0), 64'd2);
        check("full_in0_ready", 64'(in0_ready), 64'd0);
        in0 = 32'd3; step(); step();
        check("full_hold_cnt0", 64'(cnt0), 64'd2);
        in0_valid = 1'b0;
        push_exp(32'd1, 32'd10);
        push_exp(32'd2, 32'd20);
        in1 = 32'd10; in1_valid = 1'b1; step();
        in1 = 32'd20; step();
        in1_valid = 1'b0;
        check("bp_valid_held", 64'(out_valid), 64'd1);
        out_ready = 1'b1;
        for (int i = 0; i < 6 && cnt0 != 0; i++) step();
        check("bp_drained_cnt0", 64'(cnt0), 64'd0);
        check("bp_drained_cnt1", 64'(cnt1), 64'd0);

        // Streaming: one pair per cycle.
        for (int i = 0; i < 16; i++) begin
            push_exp(W'(i), W'(i + 100));
            in0 = W'(i); in1 = W'(i + 100); in0_valid = 1'b1; in1_valid = 1'b1;
            step();
            check("stream_valid", 64'(out_valid), 64'd1);
            check("stream_cnt0", 64'(cnt0), 64'd1);
        end
        in0_valid = 1'b0; in1_valid = 1'b0;
        step(); step();
        check("stream_end_cnt1", 64'(cnt1), 64'd0);

        // Single-operand mode: in1 tokens are dropped.
        config_sig = 2'd2;
        push_exp(32'd7, 32'd0);
        push_exp(32'd8, 32'd0);
        in0 = 32'd7; in1 = 32'd99; in0_valid = 1'b1; in1_valid = 1'b1;
        check("cfg2_in1_ready", 64'(in1_ready), 64'd1);
        step();
        in0 = 32'd8;
        check("cfg2_in1_ready2", 64'(in1_ready), 64'd1);
        check("cfg2_cnt1", 64'(cnt1), 64'd0);
        step();
        in0_valid = 1'b0; in1_valid = 1'b0;
        step(); step();
        check("cfg2_end_cnt0", 64'(cnt0), 64'd0);
        check("cfg2_end_cnt1", 64'(cnt1), 64'd0);

        // Config change with a stored in1 token.
        config_sig = 2'd0; out_ready = 1'b0;
        in1 = 32'd42; in1_valid = 1'b1; step();
        in1_valid = 1'b0;
        check("cc_cnt1", 64'(cnt1), 64'd1);
        check("cc_valid_cfg0", 64'(out_valid), 64'd0);
        push_exp(32'd0, 32'd42);
        config_sig = 2'd3;
        #1;
        check("cc_valid_cfg3", 64'(out_valid), 64'd1);
        check("cc_out0", 64'(out0), 64'd0);
        out_ready = 1'b1;
        step();
        check("cc_cnt1_after", 64'(cnt1), 64'd0);
        check("cc_cnt0_after", 64'(cnt0), 64'd0);

        // Unused FIFO retains its entry across config changes.
        config_sig = 2'd0; out_ready = 1'b0;
        in0 = 32'd77; in0_valid = 1'b1; step();
        in0_valid = 1'b0;
        config_sig = 2'd3; out_ready = 1'b1;
        push_exp(32'd0, 32'd88);
        in1 = 32'd88; in1_valid = 1'b1; step();
        in1_valid = 1'b0;
        step();
        check("ret_cnt0", 64'(cnt0), 64'd1);
        check("ret_cnt1", 64'(cnt1), 64'd0);
        config_sig = 2'd0;
        push_exp(32'd77, 32'd99);
        in1 = 32'd99; in1_valid = 1'b1; step();
        in1_valid = 1'b0;
        step(); step();
        check("ret_end_cnt0", 64'(cnt0), 64'd0);

        step();
        check("queue_empty", 64'(exp_q.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
